// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// hex decode and BCD sizing.
package ssd_pkg;

    // {Ca..Cg}, active low
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        B2B_IDLE,
        B2B_SHIFT,
        B2B_DONE
    } b2b_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

    // ceil(bin_width * 1.21 / 4) in integer arithmetic
    function automatic int unsigned bcd_digits(input int unsigned bin_width);
        return (bin_width * 121 + 399) / 400;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_bin2bcd.sv
// Sequential double-dabble converter, one binary bit per clock; bcd holds
// the result during the single DONE cycle.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 16
) (
    input  logic                                 board_clk,
    input  logic                                 Reset,
    input  logic                                 start,
    input  logic [BIN_WIDTH-1:0]                 bin,
    output logic                                 busy,
    output logic                                 done,
    output logic [4*bcd_digits(BIN_WIDTH)-1:0]   bcd
);

    localparam int unsigned BCD_DIGITS = bcd_digits(BIN_WIDTH);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W      = $clog2(BIN_WIDTH);

    b2b_state_t           state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]     bcd_q, bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_iter;

    assign last_iter = (cnt_q == CNT_W'(BIN_WIDTH - 1));

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state_q <= B2B_IDLE;
        else       state_q <= state_d;
    end

    // DONE accepts a new start so back-to-back loads are not lost
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            B2B_IDLE: begin
                if (start) state_d = B2B_SHIFT;
            end
            B2B_SHIFT: begin
                busy = 1'b1;
                if (last_iter) state_d = B2B_DONE;
            end
            B2B_DONE: begin
                done    = 1'b1;
                state_d = start ? B2B_SHIFT : B2B_IDLE;
            end
            default: state_d = B2B_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state_q == B2B_SHIFT) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
            bin_q <= {bin_q[BIN_WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller: load arbitration, display register,
// digit prescaler/index and registered anode/cathode drive.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned BIN_WIDTH     = 16,
    parameter int unsigned SCAN_DIV_BITS = 18
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic                    mode,
    input  logic [BIN_WIDTH-1:0]    bin_value,
    input  logic [4*NUM_DIGITS-1:0] hex_value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    ovf,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cathodes
);

    localparam int unsigned BCD_DIGITS = bcd_digits(BIN_WIDTH);
    localparam int unsigned EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    logic                      conv_busy, conv_done, accept;
    logic [4*BCD_DIGITS-1:0]   bcd;
    logic [4*EXT_DIGITS-1:0]   bcd_ext;
    logic                      bcd_ovf;
    logic [4*NUM_DIGITS-1:0]   disp_q;
    logic                      ovf_q;
    logic [SCAN_DIV_BITS-1:0]  presc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_DIGITS-1:0]     nz_from;
    logic                      nz_run;
    logic [3:0]                cur_nib;
    logic                      cur_en, cur_dp, cur_nz, dark;
    logic [NUM_DIGITS-1:0]     an_next;
    logic [7:0]                cath_next;

    assign accept = load & ~conv_busy;

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_bin2bcd (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start     (accept & ~mode),
        .bin       (bin_value),
        .busy      (conv_busy),
        .done      (conv_done),
        .bcd       (bcd)
    );

    // Zero-extend so the split into shown/overflow digits works whether the
    // converter is wider or narrower than the display.
    always_comb begin
        bcd_ext                   = '0;
        bcd_ext[4*BCD_DIGITS-1:0] = bcd;
        bcd_ovf                   = |(bcd_ext >> (4 * NUM_DIGITS));
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (accept && mode) begin
            disp_q <= hex_value;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= bcd_ext[4*NUM_DIGITS-1:0];
            ovf_q  <= bcd_ovf;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // nz_from[i]: some digit at position i or above is nonzero
    always_comb begin
        nz_from = '0;
        nz_run  = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            nz_run                     = nz_run | (|disp_q[4*(NUM_DIGITS-1-k) +: 4]);
            nz_from[NUM_DIGITS-1-k]    = nz_run;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_nz  = 1'b0;
        an_next = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = disp_q[4*i +: 4];
                cur_en  = digit_en[i];
                cur_dp  = dp_mask[i];
                cur_nz  = nz_from[i];
            end
        end
        dark = ~cur_en | (blank_lz & (idx_q != '0) & ~cur_nz);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) an_next[i] = dark;
        end
        cath_next = dark ? 8'hFF : {hex_to_seg(cur_nib), ~cur_dp};
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            An       <= '1;
            Cathodes <= 8'hFF;
        end else begin
            An       <= an_next;
            Cathodes <= cath_next;
        end
    end

    assign busy = conv_busy;
    assign ovf  = ovf_q;

endmodule
